six_phase_seq_ctrl: RTL and testbench
=====================================

Name: six_phase_seq_ctrl

Overview:
Run controller for the team's six-state phase sequence: 000→001→011→111→110→100→000. It owns the phase register and sequences it through a programmed number of full rotations, or continuously. It supports pause, single-step and abort. Downstream logic consumes the decoded phase and the completion/wrap pulses.

Parameters:
RW, 8, width of rotation-count input and completed-rotation counter

Ports:
clk  input  1  clock, rising edge
rstb  input  1  reset, asynchronous, active-low
start  input  1  level sampled each edge; launches a run from IDLE, resumes from HOLD
stop  input  1  pause request while RUN
abort  input  1  cancel run from RUN or HOLD, return to IDLE
step  input  1  in HOLD only: advance exactly one phase per sampled-high cycle
continuous  input  1  latched at launch; 1 = run until stop/abort, ignore rot_count
rot_count  input  RW  number of full rotations for one-shot run; latched at launch
phase  output  3  current phase code (registered)
phase_oh  output  6  one-hot decode of phase: bit0=000, bit1=001, bit2=011, bit3=111, bit4=110, bit5=100
busy  output  1  high in RUN or HOLD
paused  output  1  high in HOLD
done  output  1  one-cycle pulse, high while state is DONE
wrap  output  1  one-cycle pulse in the cycle after phase moved 100→000
rotations  output  RW  completed rotations since last launch

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, phase=000, rotations=0, latched count/mode cleared. All outputs 0 except phase_oh=000001.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered or decoded from registered state/phase; no combinational input→output paths.
- Input priority when several are sampled high in the same cycle: abort > stop > start > step.
- IDLE:
  - start=1: latch rot_count and continuous, clear rotations, phase stays 000.
  - If one-shot and rot_count=0, go to DONE with no phase movement. Otherwise go to RUN.
  - stop, step and abort are ignored.
- RUN:
  - Phase advances one step per edge. First advance occurs on the edge after the launch edge.
  - Each 100→000 transition increments rotations (modulo 2^RW) and asserts wrap for the following cycle.
  - One-shot: the edge that makes rotations equal the latched count moves to DONE. Phase=000 at that point.
  - A one-shot run of N rotations therefore reaches DONE exactly 6N edges after the launch edge.
  - stop → HOLD, phase frozen at its current value. The stop edge does not advance the phase.
  - abort → IDLE, phase=000, rotations keep their value.
  - start is ignored.
- HOLD:
  - start → RUN; the latched count is not reloaded.
  - step=1 advances one phase, with the same wrap and completion rules as RUN. If that step completes the final one-shot rotation, go to DONE.
  - A step held high for k cycles gives k advances.
  - abort → IDLE, phase=000.
- DONE: lasts one cycle. done=1, busy=0. Next state is IDLE unconditionally; inputs in the DONE cycle are ignored.
- Phase register never holds 010 or 101. If either code is ever decoded (e.g., SEU), next phase is 000 and phase_oh is all-zero for that cycle.
- rot_count=2^RW−1 is legal and must complete without overflow of the compare.

Test Plan:
1. Reset release, then start=1 for one cycle, rot_count=2, continuous=0 → phase walks 001,011,111,110,100,000 twice. wrap pulses after edges 6 and 12. done high in the cycle after edge 12. rotations=2, busy falls with done.
2. start with rot_count=0, one-shot → done pulse on the next cycle, phase stays 000, wrap never asserted, busy never asserted.
3. Continuous run, stop asserted when phase=111 → paused=1, phase holds 111 for 5 cycles. step pulsed 3 times → 110,100,000, with wrap once. start → RUN resumes from 000.
4. One-shot rot_count=1 paused at phase 100, then step=1 → phase 000, wrap=1, done pulse next cycle, state IDLE.
5. abort and stop asserted together in RUN → IDLE, phase=000, no done. Then start with stop held high → launches RUN, and stop takes effect on the following edge.
6. rstb pulsed low mid-RUN (phase 011, rotations=3) → immediate async clear: phase 000, rotations 0, busy 0. Asserts with no clock edge.

Source files
------------

// File: rtl/six_phase_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : six_phase_seq_ctrl
// Purpose  : Run controller for the six-state phase sequence
//            000 -> 001 -> 011 -> 111 -> 110 -> 100 -> 000.
//            Steps the phase register through a programmed number of full
//            rotations (one-shot) or indefinitely (continuous), with pause,
//            single-step and abort.
// Ports    : clk, rstb (async active-low)
//            start/stop/abort/step  run control (abort > stop > start > step)
//            continuous, rot_count  run mode and length, latched at launch
//            phase, phase_oh        registered phase and its one-hot decode
//            busy, paused, done     state decode (RUN|HOLD, HOLD, DONE)
//            wrap                   pulse in the cycle after 100 -> 000
//            rotations              completed rotations since last launch
// Revision : 1.0 - initial release
// ============================================================================
module six_phase_seq_ctrl #(
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          start,
    input  logic          stop,
    input  logic          abort,
    input  logic          step,
    input  logic          continuous,
    input  logic [RW-1:0] rot_count,
    output logic [2:0]    phase,
    output logic [5:0]    phase_oh,
    output logic          busy,
    output logic          paused,
    output logic          done,
    output logic          wrap,
    output logic [RW-1:0] rotations
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [RW-1:0] rot_q,   rot_d;
    logic [RW-1:0] cnt_q,   cnt_d;
    logic          cont_q,  cont_d;
    logic          wrap_q,  wrap_d;

    logic          w_adv;
    logic          w_valid;
    logic [2:0]    w_next_phase;
    logic [RW-1:0] w_rot_inc;

    // Successor in the sequence; the two unused codes recover to 000.
    always_comb begin
        w_valid      = 1'b1;
        w_next_phase = 3'b000;
        case (phase_q)
            3'b000:  w_next_phase = 3'b001;
            3'b001:  w_next_phase = 3'b011;
            3'b011:  w_next_phase = 3'b111;
            3'b111:  w_next_phase = 3'b110;
            3'b110:  w_next_phase = 3'b100;
            3'b100:  w_next_phase = 3'b000;
            default: begin
                w_valid      = 1'b0;
                w_next_phase = 3'b000;
            end
        endcase
    end

    assign w_rot_inc = rot_q + 1'b1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        wrap_d  = 1'b0;
        w_adv   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = rot_count;
                    cont_d  = continuous;
                    rot_d   = '0;
                    phase_d = 3'b000;
                    // A zero-length one-shot completes without moving.
                    if (!continuous && (rot_count == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    phase_d = 3'b000;
                end else if (stop) begin
                    state_d = S_HOLD;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    phase_d = 3'b000;
                end else if (stop) begin
                    // stop outranks start/step: remain paused
                    state_d = S_HOLD;
                end else if (start) begin
                    state_d = S_RUN;
                end else if (step) begin
                    w_adv = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_adv) begin
            phase_d = w_next_phase;
            if (phase_q == 3'b100) begin
                rot_d  = w_rot_inc;
                wrap_d = 1'b1;
                // Compare the incremented value so a count of all-ones
                // finishes on its last rotation without overflowing.
                if (!cont_q && (w_rot_inc == cnt_q)) begin
                    state_d = S_DONE;
                end
            end
        end else if (!w_valid) begin
            phase_d = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            phase_q <= 3'b000;
            rot_q   <= '0;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            wrap_q  <= wrap_d;
        end
    end

    // Unused codes decode to all-zero.
    always_comb begin
        phase_oh = 6'b000000;
        case (phase_q)
            3'b000:  phase_oh = 6'b000001;
            3'b001:  phase_oh = 6'b000010;
            3'b011:  phase_oh = 6'b000100;
            3'b111:  phase_oh = 6'b001000;
            3'b110:  phase_oh = 6'b010000;
            3'b100:  phase_oh = 6'b100000;
            default: phase_oh = 6'b000000;
        endcase
    end

    assign phase     = phase_q;
    assign rotations = rot_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
    assign paused    = (state_q == S_HOLD);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_six_phase_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_six_phase_seq_ctrl
// Purpose  : Self-checking bench for six_phase_seq_ctrl. Cycle-by-cycle
//            vector table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_six_phase_seq_ctrl;

    logic       clk;
    logic       rstb;
    logic       start, stop, abort, step, continuous;
    logic [7:0] rot_count;
    logic [2:0] phase;
    logic [5:0] phase_oh;
    logic       busy, paused, done, wrap;
    logic [7:0] rotations;

    int total = 0;
    int bad   = 0;

    six_phase_seq_ctrl #(.RW(8)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .stop       (stop),
        .abort      (abort),
        .step       (step),
        .continuous (continuous),
        .rot_count  (rot_count),
        .phase      (phase),
        .phase_oh   (phase_oh),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .wrap       (wrap),
        .rotations  (rotations)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, abort, step, cont;
        logic [7:0] rc;
        logic [2:0] ph;
        logic       busy, paused, done, wrap;
        logic [7:0] rot;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] oh_of(input logic [2:0] p);
        case (p)
            3'b000:  return 6'b000001;
            3'b001:  return 6'b000010;
            3'b011:  return 6'b000100;
            3'b111:  return 6'b001000;
            3'b110:  return 6'b010000;
            3'b100:  return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic sp, input logic ab,
                       input logic st, input logic c, input logic [7:0] rc,
                       input logic [2:0] ph, input logic b, input logic pa,
                       input logic d, input logic w, input logic [7:0] rot);
        vec_t v;
        v.start = s;  v.stop = sp; v.abort = ab; v.step = st; v.cont = c;
        v.rc = rc;    v.ph = ph;   v.busy = b;   v.paused = pa;
        v.done = d;   v.wrap = w;  v.rot = rot;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic sp, input logic ab,
                         input logic st, input logic c, input logic [7:0] rc);
        start = s; stop = sp; abort = ab; step = st;
        continuous = c; rot_count = rc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ph,
                           input logic b, input logic pa, input logic d,
                           input logic w, input logic [7:0] rot);
        chk({tag, ".phase"},     {29'd0, phase},    {29'd0, ph});
        chk({tag, ".phase_oh"},  {26'd0, phase_oh}, {26'd0, oh_of(ph)});
        chk({tag, ".busy"},      {31'd0, busy},     {31'd0, b});
        chk({tag, ".paused"},    {31'd0, paused},   {31'd0, pa});
        chk({tag, ".done"},      {31'd0, done},     {31'd0, d});
        chk({tag, ".wrap"},      {31'd0, wrap},     {31'd0, w});
        chk({tag, ".rotations"}, {24'd0, rotations}, {24'd0, rot});
    endtask

    initial begin
        logic [2:0] seq [5];
        int         edges;
        bit         seen;
        seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b111;
        seq[3] = 3'b110; seq[4] = 3'b100;

        // ---------------- vector table ----------------
        // Plan 1: one-shot, two rotations
        add(1,0,0,0,0,8'd2, 3'b000,1,0,0,0,8'd0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++)
                add(0,0,0,0,0,8'd0, seq[i],1,0,0,0,8'(r));
            if (r == 0) add(0,0,0,0,0,8'd0, 3'b000,1,0,0,1,8'd1);
            else        add(0,0,0,0,0,8'd0, 3'b000,0,0,1,1,8'd2);
        end
        add(0,0,0,0,0,8'd0, 3'b000,0,0,0,0,8'd2);
        // stop/step/abort in IDLE are ignored
        add(0,1,1,1,0,8'd0, 3'b000,0,0,0,0,8'd2);
        // Plan 2: zero-length one-shot
        add(1,0,0,0,0,8'd0, 3'b000,0,0,1,0,8'd0);
        add(0,0,0,0,0,8'd0, 3'b000,0,0,0,0,8'd0);
        // Plan 3: continuous, stop at 111, hold, step x3, resume, abort
        add(1,0,0,0,1,8'd0, 3'b000,1,0,0,0,8'd0);
        add(0,0,0,0,0,8'd0, 3'b001,1,0,0,0,8'd0);
        add(0,0,0,0,0,8'd0, 3'b011,1,0,0,0,8'd0);
        add(0,0,0,0,0,8'd0, 3'b111,1,0,0,0,8'd0);
        add(0,1,0,0,0,8'd0, 3'b111,1,1,0,0,8'd0);
        for (int i = 0; i < 5; i++)
            add(0,0,0,0,0,8'd0, 3'b111,1,1,0,0,8'd0);
        add(0,0,0,1,0,8'd0, 3'b110,1,1,0,0,8'd0);
        add(0,0,0,1,0,8'd0, 3'b100,1,1,0,0,8'd0);
        add(0,0,0,1,0,8'd0, 3'b000,1,1,0,1,8'd1);
        add(0,0,0,0,0,8'd0, 3'b000,1,1,0,0,8'd1);
        add(1,0,0,0,0,8'd0, 3'b000,1,0,0,0,8'd1);
        add(0,0,0,0,0,8'd0, 3'b001,1,0,0,0,8'd1);
        add(0,0,1,0,0,8'd0, 3'b000,0,0,0,0,8'd1);
        // Plan 5: abort+stop together, then start with stop held
        add(1,0,0,0,1,8'd0, 3'b000,1,0,0,0,8'd0);
        add(0,0,0,0,0,8'd0, 3'b001,1,0,0,0,8'd0);
        add(0,1,1,0,0,8'd0, 3'b000,0,0,0,0,8'd0);
        add(1,1,0,0,1,8'd0, 3'b000,1,0,0,0,8'd0);
        add(0,1,0,0,0,8'd0, 3'b000,1,1,0,0,8'd0);
        add(1,1,0,1,0,8'd0, 3'b000,1,1,0,0,8'd0);
        add(0,0,1,0,0,8'd0, 3'b000,0,0,0,0,8'd0);

        // ---------------- reset ----------------
        drive(0,0,0,0,0,8'd0);
        rstb = 1'b0;
        #12;
        chk_all("reset", 3'b000, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            drive(vecs[k].start, vecs[k].stop, vecs[k].abort,
                  vecs[k].step, vecs[k].cont, vecs[k].rc);
            tick();
            chk_all($sformatf("vec%0d", k), vecs[k].ph, vecs[k].busy,
                    vecs[k].paused, vecs[k].done, vecs[k].wrap, vecs[k].rot);
        end
        drive(0,0,0,0,0,8'd0);

        // Plan 4: one-shot of 1, pause at 100, final rotation by step
        drive(1,0,0,0,0,8'd1);
        tick();
        drive(0,0,0,0,0,8'd0);
        for (int i = 0; i < 5; i++) tick();
        chk_all("p4_at100", 3'b100, 1, 0, 0, 0, 8'd0);
        drive(0,1,0,0,0,8'd0);
        tick();
        chk_all("p4_hold", 3'b100, 1, 1, 0, 0, 8'd0);
        drive(0,0,0,1,0,8'd0);
        tick();
        chk_all("p4_step", 3'b000, 0, 0, 1, 1, 8'd1);
        drive(0,0,0,0,0,8'd0);
        tick();
        chk_all("p4_idle", 3'b000, 0, 0, 0, 0, 8'd1);

        // Largest count: 255 rotations must end exactly 1530 edges later
        drive(1,0,0,0,0,8'd255);
        tick();
        drive(0,0,0,0,0,8'd0);
        edges = 0;
        seen  = 1'b0;
        while (edges < 2000 && !seen) begin
            tick();
            edges++;
            if (done) seen = 1'b1;
        end
        chk("max_done_edge", edges, 1530);
        chk("max_rotations", {24'd0, rotations}, 32'd255);
        tick();
        chk("max_idle_busy", {31'd0, busy}, 32'd0);

        // Plan 6: async reset mid-run at phase 011, rotations 3
        drive(1,0,0,0,1,8'd0);
        tick();
        drive(0,0,0,0,0,8'd0);
        for (int i = 0; i < 20; i++) tick();
        chk_all("p6_pre", 3'b011, 1, 0, 0, 0, 8'd3);
        #2;
        rstb = 1'b0;
        #1;
        chk_all("p6_async", 3'b000, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rstb = 1'b1;
        tick();
        chk_all("p6_after", 3'b000, 0, 0, 0, 0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
